// File: rtl/pipe_ctrl.sv
// Pipeline stage controller: per-stage enable/reset strobes, upstream stall
// propagation and a debug run/drain/halt/single-step state machine.
module pipe_ctrl #(
    parameter int unsigned if_lanes  = 4,
    parameter int unsigned id_lanes  = 2,
    parameter int unsigned be_stages = 3,
    parameter int unsigned step_freq = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [if_lanes-1:0]  mgr_if_en,
    input  logic [if_lanes-1:0]  mgr_if_rst,
    input  logic [id_lanes-1:0]  mgr_id_en,
    input  logic [id_lanes-1:0]  mgr_id_rst,
    input  logic [be_stages-1:0] be_stall,
    input  logic [be_stages-1:0] be_valid,
    input  logic                 issue,
    input  logic                 retire,
    input  logic                 dbg_halt_req,
    input  logic                 dbg_resume,
    input  logic                 dbg_step,
    output logic [if_lanes-1:0]  if_en,
    output logic [if_lanes-1:0]  if_rst,
    output logic [id_lanes-1:0]  id_en,
    output logic [id_lanes-1:0]  id_rst,
    output logic [be_stages-1:0] be_en,
    output logic [be_stages-1:0] be_rst,
    output logic                 halted,
    output logic [31:0]          retire_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    localparam logic [31:0] STEP_LAST = (step_freq == 0) ? '0 : 32'(step_freq - 1);

    state_t               r_state;
    logic [31:0]          r_step_cnt;
    logic [31:0]          r_retire_cnt;
    logic [be_stages-1:0] w_stall_at;
    logic                 w_fe_ok;
    logic                 w_live;

    // A stall at stage j freezes j and everything upstream of it.
    always_comb begin
        w_stall_at = '0;
        for (int unsigned k = 0; k < be_stages; k++) begin
            for (int unsigned j = k; j < be_stages; j++) begin
                if (be_stall[j]) w_stall_at[k] = 1'b1;
            end
        end
    end

    assign w_live  = en && !rst;
    assign w_fe_ok = ((r_state == S_RUN) || (r_state == S_STEP)) && !w_stall_at[0];

    assign if_en  = (w_live && w_fe_ok) ? mgr_if_en : '0;
    assign id_en  = (w_live && w_fe_ok) ? mgr_id_en : '0;
    assign if_rst = {if_lanes{rst}} | mgr_if_rst;
    assign id_rst = {id_lanes{rst}} | mgr_id_rst;
    assign be_en  = (w_live && (r_state != S_HALTED)) ? ~w_stall_at : '0;
    assign be_rst = {be_stages{rst}};

    assign halted     = (r_state == S_HALTED);
    assign retire_cnt = r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_step_cnt   <= '0;
            r_retire_cnt <= '0;
        end else if (en) begin
            if (retire) r_retire_cnt <= r_retire_cnt + 32'd1;
            unique case (r_state)
                S_RUN: begin
                    if (dbg_halt_req) begin
                        r_state    <= S_DRAIN;
                        r_step_cnt <= '0;
                    end else if ((step_freq != 0) && retire && (r_step_cnt == STEP_LAST)) begin
                        r_state    <= S_DRAIN;
                        r_step_cnt <= '0;
                    end else if (retire) begin
                        r_step_cnt <= r_step_cnt + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (be_valid == '0) r_state <= S_HALTED;
                end
                S_HALTED: begin
                    if (dbg_resume) begin
                        r_state    <= S_RUN;
                        r_step_cnt <= '0;
                    end else if (dbg_step) begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (dbg_halt_req || issue) r_state <= S_DRAIN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (step_freq = 10).
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] mgr_if_en, mgr_if_rst;
    logic [1:0] mgr_id_en, mgr_id_rst;
    logic [2:0] be_stall, be_valid;
    logic       issue, retire, dbg_halt_req, dbg_resume, dbg_step;
    logic [3:0] if_en, if_rst;
    logic [1:0] id_en, id_rst;
    logic [2:0] be_en, be_rst;
    logic       halted;
    logic [31:0] retire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.if_lanes(4), .id_lanes(2), .be_stages(3), .step_freq(10)) dut (
        .clk(clk), .rst(rst), .en(en),
        .mgr_if_en(mgr_if_en), .mgr_if_rst(mgr_if_rst),
        .mgr_id_en(mgr_id_en), .mgr_id_rst(mgr_id_rst),
        .be_stall(be_stall), .be_valid(be_valid),
        .issue(issue), .retire(retire),
        .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
        .if_en(if_en), .if_rst(if_rst), .id_en(id_en), .id_rst(id_rst),
        .be_en(be_en), .be_rst(be_rst), .halted(halted), .retire_cnt(retire_cnt)
    );

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        mgr_if_en = 4'hF; mgr_if_rst = 4'h0; mgr_id_en = 2'h3; mgr_id_rst = 2'h0;
        be_stall = 3'b000; be_valid = 3'b000;
        issue = 1'b0; retire = 1'b0;
        dbg_halt_req = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({if_rst, id_rst, be_rst} !== 9'h1FF) begin n_err++;
            $display("FAIL reset_rst: got %b want 111111111", {if_rst, id_rst, be_rst}); end
        n_cmp++; if ({if_en, id_en, be_en} !== 9'h000) begin n_err++;
            $display("FAIL reset_en: got %b want 000000000", {if_en, id_en, be_en}); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (halted !== 1'b0) begin n_err++;
            $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (retire_cnt !== 32'd0) begin n_err++;
            $display("FAIL reset_retire_cnt: got %0d want 0", retire_cnt); end
        n_cmp++; if ({if_en, id_en, be_en} !== 9'h1FF) begin n_err++;
            $display("FAIL run_en: got %b want 111111111", {if_en, id_en, be_en}); end
    endtask

    task automatic test_stall();
        @(negedge clk); be_stall = 3'b010; #1;
        n_cmp++; if ({be_en, if_en, id_en} !== {3'b100, 4'h0, 2'h0}) begin n_err++;
            $display("FAIL stall_mid: got be=%b if=%b id=%b want be=100 if=0000 id=00", be_en, if_en, id_en); end
        be_stall = 3'b100; #1;
        n_cmp++; if (be_en !== 3'b000) begin n_err++;
            $display("FAIL stall_wb: got %b want 000", be_en); end
        be_stall = 3'b001; #1;
        n_cmp++; if ({be_en, if_en} !== {3'b110, 4'h0}) begin n_err++;
            $display("FAIL stall_ex: got be=%b if=%b want be=110 if=0000", be_en, if_en); end
        @(negedge clk); be_stall = 3'b000; #1;
        n_cmp++; if ({if_en, id_en, be_en} !== 9'h1FF) begin n_err++;
            $display("FAIL stall_release: got %b want 111111111", {if_en, id_en, be_en}); end
        mgr_if_en = 4'b1010; mgr_if_rst = 4'b0101; mgr_id_en = 2'b01; mgr_id_rst = 2'b10; #1;
        n_cmp++; if ({if_en, if_rst, id_en, id_rst} !== {4'b1010, 4'b0101, 2'b01, 2'b10}) begin n_err++;
            $display("FAIL mgr_pass: got %b want 1010010101 10", {if_en, if_rst, id_en, id_rst}); end
        mgr_if_en = 4'hF; mgr_if_rst = 4'h0; mgr_id_en = 2'h3; mgr_id_rst = 2'h0;
    endtask

    task automatic test_halt_drain();
        @(negedge clk); be_valid = 3'b111; dbg_halt_req = 1'b1; #1;
        n_cmp++; if (if_en !== 4'hF) begin n_err++;
            $display("FAIL halt_same_cycle: got %b want 1111", if_en); end
        @(negedge clk); dbg_halt_req = 1'b0; be_valid = 3'b011; #1;
        n_cmp++; if ({if_en, id_en, be_en, halted} !== {4'h0, 2'h0, 3'b111, 1'b0}) begin n_err++;
            $display("FAIL drain_enter: got %b want 000000111 0", {if_en, id_en, be_en, halted}); end
        @(negedge clk); be_valid = 3'b001; #1;
        @(negedge clk); be_valid = 3'b000; #1;
        n_cmp++; if (halted !== 1'b0) begin n_err++;
            $display("FAIL drain_hold: got %b want 0", halted); end
        @(negedge clk); #1;
        n_cmp++; if ({halted, if_en, be_en} !== {1'b1, 4'h0, 3'b000}) begin n_err++;
            $display("FAIL halted: got %b want 1 0000 000", {halted, if_en, be_en}); end
        @(negedge clk); dbg_halt_req = 1'b1; #1;
        @(negedge clk); dbg_halt_req = 1'b0; #1;
        n_cmp++; if (halted !== 1'b1) begin n_err++;
            $display("FAIL halt_req_in_halted: got %b want 1", halted); end
    endtask

    task automatic test_single_step();
        @(negedge clk); dbg_step = 1'b1; #1;
        @(negedge clk); dbg_step = 1'b0; issue = 1'b1; retire = 1'b1; #1;
        n_cmp++; if ({halted, if_en, be_en} !== {1'b0, 4'hF, 3'b111}) begin n_err++;
            $display("FAIL step_enter: got %b want 0 1111 111", {halted, if_en, be_en}); end
        @(negedge clk); issue = 1'b0; retire = 1'b0; #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'h0}) begin n_err++;
            $display("FAIL step_drain: got %b want 0 0000", {halted, if_en}); end
        @(negedge clk); #1;
        n_cmp++; if ({halted, retire_cnt} !== {1'b1, 32'd1}) begin n_err++;
            $display("FAIL step_halted: got halted=%b cnt=%0d want 1 1", halted, retire_cnt); end
    endtask

    task automatic test_resume_step_collision();
        @(negedge clk); dbg_resume = 1'b1; dbg_step = 1'b1; #1;
        @(negedge clk); dbg_resume = 1'b0; dbg_step = 1'b0; issue = 1'b1; #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'hF}) begin n_err++;
            $display("FAIL collide_state: got %b want 0 1111", {halted, if_en}); end
        @(negedge clk); issue = 1'b0; #1;
        n_cmp++; if (if_en !== 4'hF) begin n_err++;
            $display("FAIL collide_is_run: got %b want 1111", if_en); end
    endtask

    task automatic test_auto_halt();
        be_valid = 3'b111;
        @(negedge clk); retire = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clk);
        #1;
        n_cmp++; if (if_en !== 4'hF) begin n_err++;
            $display("FAIL auto_before_10: got %b want 1111", if_en); end
        @(negedge clk); retire = 1'b0; be_valid = 3'b000; #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'h0}) begin n_err++;
            $display("FAIL auto_drain: got %b want 0 0000", {halted, if_en}); end
        @(negedge clk); be_valid = 3'b111; dbg_resume = 1'b1; #1;
        n_cmp++; if ({halted, retire_cnt} !== {1'b1, 32'd11}) begin n_err++;
            $display("FAIL auto_halted: got halted=%b cnt=%0d want 1 11", halted, retire_cnt); end
        @(negedge clk); dbg_resume = 1'b0; retire = 1'b1; #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'hF}) begin n_err++;
            $display("FAIL auto_resume: got %b want 0 1111", {halted, if_en}); end
        for (int i = 0; i < 9; i++) @(negedge clk);
        #1;
        n_cmp++; if (if_en !== 4'hF) begin n_err++;
            $display("FAIL auto2_before_10: got %b want 1111", if_en); end
        @(negedge clk); retire = 1'b0; #1;
        n_cmp++; if ({if_en, retire_cnt} !== {4'h0, 32'd21}) begin n_err++;
            $display("FAIL auto2_drain: got if=%b cnt=%0d want 0000 21", if_en, retire_cnt); end
    endtask

    task automatic test_rst_in_drain();
        @(negedge clk); #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'h0}) begin n_err++;
            $display("FAIL drain_still: got %b want 0 0000", {halted, if_en}); end
        rst = 1'b1; #1;
        n_cmp++; if ({if_rst, be_rst, be_en} !== {4'hF, 3'b111, 3'b000}) begin n_err++;
            $display("FAIL drain_rst_strobes: got %b want 1111 111 000", {if_rst, be_rst, be_en}); end
        @(negedge clk); rst = 1'b0; be_valid = 3'b000; #1;
        n_cmp++; if ({halted, if_en, retire_cnt} !== {1'b0, 4'hF, 32'd0}) begin n_err++;
            $display("FAIL drain_rst_run: got halted=%b if=%b cnt=%0d want 0 1111 0", halted, if_en, retire_cnt); end
    endtask

    task automatic test_global_enable();
        @(negedge clk); en = 1'b0; retire = 1'b1; dbg_halt_req = 1'b1; #1;
        n_cmp++; if ({if_en, id_en, be_en} !== 9'h000) begin n_err++;
            $display("FAIL en_low: got %b want 000000000", {if_en, id_en, be_en}); end
        @(negedge clk); #1;
        @(negedge clk); en = 1'b1; retire = 1'b0; dbg_halt_req = 1'b0; #1;
        n_cmp++; if (retire_cnt !== 32'd0) begin n_err++;
            $display("FAIL en_low_cnt: got %0d want 0", retire_cnt); end
        @(negedge clk); #1;
        n_cmp++; if ({halted, if_en} !== {1'b0, 4'hF}) begin n_err++;
            $display("FAIL en_low_halt_ignored: got %b want 0 1111", {halted, if_en}); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_cnt;
        #1;
        n_cmp++; if (retire_cnt !== 32'hFFFF_FFFE) begin n_err++;
            $display("FAIL wrap_preload: got %h want fffffffe", retire_cnt); end
        retire = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (retire_cnt !== 32'hFFFF_FFFF) begin n_err++;
            $display("FAIL wrap_max: got %h want ffffffff", retire_cnt); end
        @(negedge clk); retire = 1'b0; #1;
        n_cmp++; if (retire_cnt !== 32'h0000_0000) begin n_err++;
            $display("FAIL wrap_zero: got %h want 00000000", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_halt_drain();
        test_single_step();
        test_resume_step_collision();
        test_auto_halt();
        test_rst_in_drain();
        test_global_enable();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
